// File: rtl/tl_cntr_w_left_param.sv
// Two-road traffic-light controller with protected left-turn phases,
// programmable green/yellow timing and optional skipping of idle left phases.
module tl_cntr_w_left_param #(
  parameter int CNT_W     = 4,
  parameter int G_MIN     = 2,
  parameter int G_MAX     = 8,
  parameter int L_MIN     = 1,
  parameter int L_MAX     = 4,
  parameter int YEL       = 2,
  parameter int SKIP_LEFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ta,
  input  logic             Tal,
  input  logic             Tb,
  input  logic             Tbl,
  output logic [1:0]       La,
  output logic [1:0]       Lb,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer
);

  typedef enum logic [2:0] {
    AG  = 3'd0,
    AY  = 3'd1,
    AL  = 3'd2,
    ALY = 3'd3,
    BG  = 3'd4,
    BY  = 3'd5,
    BL  = 3'd6,
    BLY = 3'd7
  } state_e;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  localparam logic [CNT_W-1:0] G_LO = CNT_W'(G_MIN - 1);
  localparam logic [CNT_W-1:0] G_HI = CNT_W'(G_MAX - 1);
  localparam logic [CNT_W-1:0] L_LO = CNT_W'(L_MIN - 1);
  localparam logic [CNT_W-1:0] L_HI = CNT_W'(L_MAX - 1);
  localparam logic [CNT_W-1:0] Y_HI = CNT_W'(YEL - 1);
  localparam logic             SKIP = (SKIP_LEFT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic g_done_a, g_done_b;
  logic l_done_a, l_done_b;
  logic y_done;

  // Min time gates every exit; max time forces one regardless of demand
  always_comb begin
    g_done_a = (timer_q >= G_LO) &&
               (!Ta || timer_q == G_HI);
    g_done_b = (timer_q >= G_LO) &&
               (!Tb || timer_q == G_HI);
    l_done_a = (timer_q >= L_LO) &&
               (!Tal || timer_q == L_HI);
    l_done_b = (timer_q >= L_LO) &&
               (!Tbl || timer_q == L_HI);
    y_done   = (timer_q == Y_HI);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AG:  if (g_done_a) state_d = AY;
      AY:  if (y_done)
             state_d = (!SKIP || Tal) ? AL : BG;
      AL:  if (l_done_a) state_d = ALY;
      ALY: if (y_done) state_d = BG;
      BG:  if (g_done_b) state_d = BY;
      BY:  if (y_done)
             state_d = (!SKIP || Tbl) ? BL : AG;
      BL:  if (l_done_b) state_d = BLY;
      BLY: if (y_done) state_d = AG;
      default: state_d = AG;
    endcase
    timer_d = (state_d != state_q) ?
              '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= AG;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    La = RED;
    Lb = RED;
    unique case (state_q)
      AG:      La = GREEN;
      AY:      La = YELLOW;
      AL:      La = LEFT;
      ALY:     La = YELLOW;
      BG:      Lb = GREEN;
      BY:      Lb = YELLOW;
      BL:      Lb = LEFT;
      BLY:     Lb = YELLOW;
      default: begin
        La = RED;
        Lb = RED;
      end
    endcase
  end

  assign phase = state_q;
  assign timer = timer_q;

endmodule

// File: tb/tb_tl_cntr_w_left_param.sv
// Scoreboard bench for tl_cntr_w_left_param: scenario tables push the
// expected phase/timer per edge; lamps are checked against a fixed table.
module tb_tl_cntr_w_left_param;

  logic clk = 1'b0;
  logic reset, Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lb, La_n, Lb_n;
  logic [2:0] phase, phase_n;
  logic [3:0] timer, timer_n;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic rst, ta, tal, tb, tbl;
  } stim_t;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] tm;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];

  logic [1:0] la_tab [8] = '{2'b00, 2'b01, 2'b10, 2'b01,
                             2'b11, 2'b11, 2'b11, 2'b11};
  logic [1:0] lb_tab [8] = '{2'b11, 2'b11, 2'b11, 2'b11,
                             2'b00, 2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;

  tl_cntr_w_left_param u_dut (
    .clk(clk), .reset(reset),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .La(La), .Lb(Lb), .phase(phase), .timer(timer)
  );

  tl_cntr_w_left_param #(.SKIP_LEFT(0)) u_ns (
    .clk(clk), .reset(reset),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .La(La_n), .Lb(Lb_n), .phase(phase_n), .timer(timer_n)
  );

  function automatic void add(logic rst, logic ta, logic tal,
                              logic tb, logic tbl, int ph, int tm);
    sq.push_back(stim_t'{rst, ta, tal, tb, tbl});
    eq.push_back(exp_t'{3'(ph), 4'(tm)});
  endfunction

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    int    c = 0;
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    for (int t = 1; t <= 7; t++) add(0, 1, 0, 0, 0, 0, t);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 4, 0);
    add(0, 1, 0, 0, 0, 4, 1);
    add(0, 1, 0, 0, 0, 5, 0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {reset, Ta, Tal, Tb, Tbl} = s;
      @(posedge clk); #1;
      e = eq.pop_front();
      vectors++;
      if ({La, Lb, phase, timer} !==
          {la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm}) begin
        errors++;
        $display("FAIL reset_maxgreen cyc %0d: got La=%b Lb=%b ph=%0d tm=%0d exp La=%b Lb=%b ph=%0d tm=%0d",
                 c, La, Lb, phase, timer,
                 la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm);
      end
      c++;
    end
  endtask

  task automatic test_idle();
    stim_t s;
    exp_t  e;
    int    c = 0;
    int    seq [4] = '{0, 1, 4, 5};
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 2; r++)
      for (int k = 1; k < 5; k++)
        for (int t = 0; t < 2; t++)
          add(0, 0, 0, 0, 0, seq[k % 4], t);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {reset, Ta, Tal, Tb, Tbl} = s;
      @(posedge clk); #1;
      e = eq.pop_front();
      vectors++;
      if ({La, Lb, phase, timer} !==
          {la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm}) begin
        errors++;
        $display("FAIL idle_cycle cyc %0d: got La=%b Lb=%b ph=%0d tm=%0d exp La=%b Lb=%b ph=%0d tm=%0d",
                 c, La, Lb, phase, timer,
                 la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm);
      end
      c++;
    end
  endtask

  task automatic test_left_a_max();
    stim_t s;
    exp_t  e;
    int    c = 0;
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1);
    for (int t = 0; t < 4; t++) add(0, 0, 1, 0, 0, 2, t);
    add(0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 1, 0, 0, 3, 1);
    add(0, 0, 1, 0, 0, 4, 0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {reset, Ta, Tal, Tb, Tbl} = s;
      @(posedge clk); #1;
      e = eq.pop_front();
      vectors++;
      if ({La, Lb, phase, timer} !==
          {la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm}) begin
        errors++;
        $display("FAIL left_a_max cyc %0d: got La=%b Lb=%b ph=%0d tm=%0d exp La=%b Lb=%b ph=%0d tm=%0d",
                 c, La, Lb, phase, timer,
                 la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm);
      end
      c++;
    end
  endtask

  task automatic test_left_b_min();
    stim_t s;
    exp_t  e;
    int    c = 0;
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 5, 1);
    add(0, 0, 0, 0, 1, 6, 0);
    add(0, 0, 0, 0, 0, 7, 0);
    add(0, 0, 0, 0, 0, 7, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {reset, Ta, Tal, Tb, Tbl} = s;
      @(posedge clk); #1;
      e = eq.pop_front();
      vectors++;
      if ({La, Lb, phase, timer} !==
          {la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm}) begin
        errors++;
        $display("FAIL left_b_min cyc %0d: got La=%b Lb=%b ph=%0d tm=%0d exp La=%b Lb=%b ph=%0d tm=%0d",
                 c, La, Lb, phase, timer,
                 la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm);
      end
      c++;
    end
  endtask

  task automatic test_reset_mid_left();
    stim_t s;
    exp_t  e;
    int    c = 0;
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 5, 1);
    add(0, 0, 0, 0, 1, 6, 0);
    add(0, 0, 0, 0, 1, 6, 1);
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {reset, Ta, Tal, Tb, Tbl} = s;
      @(posedge clk); #1;
      e = eq.pop_front();
      vectors++;
      if ({La, Lb, phase, timer} !==
          {la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm}) begin
        errors++;
        $display("FAIL reset_mid_left cyc %0d: got La=%b Lb=%b ph=%0d tm=%0d exp La=%b Lb=%b ph=%0d tm=%0d",
                 c, La, Lb, phase, timer,
                 la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm);
      end
      c++;
    end
  endtask

  task automatic test_no_skip();
    stim_t s;
    exp_t  e;
    int    c = 0;
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 3, 1);
    add(0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 4, 1);
    add(0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 5, 1);
    add(0, 0, 0, 0, 0, 6, 0);
    add(0, 0, 0, 0, 0, 7, 0);
    add(0, 0, 0, 0, 0, 7, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {reset, Ta, Tal, Tb, Tbl} = s;
      @(posedge clk); #1;
      e = eq.pop_front();
      vectors++;
      if ({La_n, Lb_n, phase_n, timer_n} !==
          {la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm}) begin
        errors++;
        $display("FAIL no_skip cyc %0d: got La=%b Lb=%b ph=%0d tm=%0d exp La=%b Lb=%b ph=%0d tm=%0d",
                 c, La_n, Lb_n, phase_n, timer_n,
                 la_tab[e.ph], lb_tab[e.ph], e.ph, e.tm);
      end
      vectors++;
      if (La_n != 2'b11 && Lb_n != 2'b11) begin
        errors++;
        $display("FAIL no_skip_conflict cyc %0d: got La=%b Lb=%b exp one RED",
                 c, La_n, Lb_n);
      end
      c++;
    end
  endtask

  initial begin
    reset = 1'b1;
    Ta = 1'b0; Tal = 1'b0;
    Tb = 1'b0; Tbl = 1'b0;
    test_reset();
    test_idle();
    test_left_a_max();
    test_left_b_min();
    test_reset_mid_left();
    test_no_skip();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
